// File: rtl/ccff_pkg.sv
// Shared state encoding and CRC constants for the configuration-chain loader.
package ccff_pkg;

    typedef logic [2:0] ccff_state_t;

    localparam ccff_state_t IDLE  = 3'd0;
    localparam ccff_state_t FETCH = 3'd1;
    localparam ccff_state_t SHIFT = 3'd2;
    localparam ccff_state_t CHECK = 3'd3;
    localparam ccff_state_t DONE  = 3'd4;
    localparam ccff_state_t ERROR = 3'd5;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/ccff_loader_if.sv
// Byte-wide valid/ready bitstream channel into the configuration-chain loader.
interface ccff_loader_if;

    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);

endinterface

// File: rtl/ccff_crc16.sv
// Serial CRC-16-CCITT, one message bit per enabled cycle, MSB-first.
module ccff_crc16
    import ccff_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ din) ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ccff_loader.sv
// Serialises a byte-wide bitstream MSB-first onto the config chain head (ccff_head/ccff_shift_en).
// Define CCFF_LOADER_CRC_EN to require a trailing CRC-16 over the shifted bits.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 20
) (
    input  logic         prog_clk,
    input  logic         prog_reset_n,
    input  logic         start,
    ccff_loader_if.slave cfg,
    output logic         ccff_head,
    output logic         ccff_shift_en,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int unsigned NBYTES = (CHAIN_LEN + 7) / 8;
    localparam int unsigned CW     = $clog2(CHAIN_LEN + 1);
    localparam int unsigned BW     = $clog2(NBYTES + 1);

    localparam logic [CW-1:0] CNT_MAX   = CW'(CHAIN_LEN);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [3:0]    LAST_BITS = 4'(CHAIN_LEN - 8 * (NBYTES - 1));

    ccff_state_t   state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [3:0]    nb_q, nb_d;
    logic [CW-1:0] bitcnt_q, bitcnt_d;
    logic [BW-1:0] bytecnt_q, bytecnt_d;
    logic          ready_q, ready_d;
    logic          head_q, head_d;
    logic          shen_q, shen_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [3:0]    nb_load;
    logic          begin_load;

`ifdef CCFF_LOADER_CRC_EN
    logic [7:0]  crc_hi_q, crc_hi_d;
    logic        crc_phase_q, crc_phase_d;
    logic [15:0] crc_val;

    // The CRC sees exactly the bits presented to the chain, in the same cycle they are launched.
    ccff_crc16 u_crc (
        .clk   (prog_clk),
        .rst_n (prog_reset_n),
        .clr   (begin_load),
        .en    (shen_d),
        .din   (head_d),
        .crc   (crc_val)
    );
`endif

    assign nb_load    = (bytecnt_q == LAST_BYTE) ? LAST_BITS : 4'd8;
    assign begin_load = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        nb_d      = nb_q;
        bitcnt_d  = bitcnt_q;
        bytecnt_d = bytecnt_q;
        ready_d   = ready_q;
        head_d    = head_q;
        shen_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
`ifdef CCFF_LOADER_CRC_EN
        crc_hi_d    = crc_hi_q;
        crc_phase_d = crc_phase_q;
`endif

        case (state_q)
            FETCH: begin
                // Launch bit 7 straight from the bus so it reaches the chain the cycle after accept.
                if (cfg.cfg_valid) begin
                    head_d    = cfg.cfg_data[7];
                    shreg_d   = {cfg.cfg_data[6:0], 1'b0};
                    nb_d      = nb_load - 4'd1;
                    bitcnt_d  = bitcnt_q + CW'(1);
                    bytecnt_d = bytecnt_q + BW'(1);
                    shen_d    = 1'b1;
                    ready_d   = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (nb_q != 4'd0) begin
                    head_d   = shreg_q[7];
                    shreg_d  = {shreg_q[6:0], 1'b0};
                    nb_d     = nb_q - 4'd1;
                    bitcnt_d = bitcnt_q + CW'(1);
                    shen_d   = 1'b1;
                end else if (bitcnt_q == CNT_MAX) begin
`ifdef CCFF_LOADER_CRC_EN
                    state_d     = CHECK;
                    ready_d     = 1'b1;
                    crc_phase_d = 1'b0;
`else
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = FETCH;
                    ready_d = 1'b1;
                end
            end
`ifdef CCFF_LOADER_CRC_EN
            CHECK: begin
                if (cfg.cfg_valid) begin
                    if (!crc_phase_q) begin
                        crc_hi_d    = cfg.cfg_data;
                        crc_phase_d = 1'b1;
                    end else begin
                        ready_d = 1'b0;
                        busy_d  = 1'b0;
                        if ({crc_hi_q, cfg.cfg_data} == crc_val) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ERROR;
                            error_d = 1'b1;
                        end
                    end
                end
            end
`endif
            DONE: begin
                // Anything offered after the chain is full is an overrun.
                if (cfg.cfg_valid) begin
                    state_d = ERROR;
                    done_d  = 1'b0;
                    error_d = 1'b1;
                end
            end
            IDLE, ERROR: begin
            end
            default: state_d = IDLE;
        endcase

        if (begin_load) begin
            state_d   = FETCH;
            ready_d   = 1'b1;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            error_d   = 1'b0;
            bitcnt_d  = '0;
            bytecnt_d = '0;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            nb_q      <= '0;
            bitcnt_q  <= '0;
            bytecnt_q <= '0;
            ready_q   <= 1'b0;
            head_q    <= 1'b0;
            shen_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef CCFF_LOADER_CRC_EN
            crc_hi_q    <= '0;
            crc_phase_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            nb_q      <= nb_d;
            bitcnt_q  <= bitcnt_d;
            bytecnt_q <= bytecnt_d;
            ready_q   <= ready_d;
            head_q    <= head_d;
            shen_q    <= shen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef CCFF_LOADER_CRC_EN
            crc_hi_q    <= crc_hi_d;
            crc_phase_q <= crc_phase_d;
`endif
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shen_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: chain model plus expected-bit stream derived from the input bytes.
module tb_ccff_loader;

    localparam int unsigned CHAIN_LEN = 20;
    localparam int unsigned NBYTES    = (CHAIN_LEN + 7) / 8;

    logic prog_clk = 1'b0;
    logic prog_reset_n;
    logic start;
    logic ccff_head, ccff_shift_en, busy, done, error;

    ccff_loader_if cfg_if ();

    ccff_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .cfg           (cfg_if),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 prog_clk = ~prog_clk;

    int   checks = 0;
    int   passes = 0;
    int   shift_idx = 0;
    int   base = 0;
    logic [7:0] stream [NBYTES];
    logic exp_bits [CHAIN_LEN];
    logic chain [CHAIN_LEN];
`ifdef CCFF_LOADER_CRC_EN
    logic crc_flip = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Chain model: index 0 is the flop at ccff_head, CHAIN_LEN-1 the deepest.
    always @(posedge prog_clk) begin
        if (ccff_shift_en === 1'b1) begin
            chain[0] <= ccff_head;
            for (int k = 1; k < CHAIN_LEN; k++) chain[k] <= chain[k-1];
        end
    end

    // Compare process: every launched bit must be the next bit of the stream.
    always @(negedge prog_clk) begin
        if (ccff_shift_en === 1'b1) begin
            if (shift_idx - base < CHAIN_LEN) check("head_bit", 32'(ccff_head), 32'(exp_bits[shift_idx - base]));
            else check("shift_overrun", 32'(shift_idx - base), 32'(CHAIN_LEN - 1));
            shift_idx++;
        end
    end

    function automatic logic [CHAIN_LEN-1:0] chain_vec();
        logic [CHAIN_LEN-1:0] v;
        for (int k = 0; k < CHAIN_LEN; k++) v[k] = chain[k];
        return v;
    endfunction

    function automatic logic [CHAIN_LEN-1:0] exp_vec();
        logic [CHAIN_LEN-1:0] v;
        for (int i = 0; i < CHAIN_LEN; i++) v[CHAIN_LEN-1-i] = exp_bits[i];
        return v;
    endfunction

`ifdef CCFF_LOADER_CRC_EN
    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            fb = c[15] ^ exp_bits[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction
`endif

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic pulse_start();
        base  = shift_idx;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit is_payload);
        int k;
        repeat (gap) tick();
        cfg_if.cfg_data  = b;
        cfg_if.cfg_valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            if (cfg_if.cfg_ready === 1'b1) break;
            tick();
        end
        if (k == 50) check("ready_timeout", 32'(k), 32'(0));
        tick();
        cfg_if.cfg_valid = 1'b0;
        if (is_payload) begin
            check("first_bit_latency", 32'(ccff_shift_en), 32'(1));
            check("first_bit_value", 32'(ccff_head), 32'(b[7]));
        end
    endtask

    task automatic load_stream(input int gap, input bit poke_start);
`ifdef CCFF_LOADER_CRC_EN
        logic [15:0] c;
`endif
        pulse_start();
        check("start_clears_flags", {30'd0, done, error}, 32'd0);
        for (int i = 0; i < NBYTES; i++) begin
            send_byte(stream[i], gap, 1'b1);
            if (poke_start && i == 0) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check("busy_after_poke", 32'(busy), 32'(1));
            end
        end
`ifdef CCFF_LOADER_CRC_EN
        c = model_crc();
        send_byte(c[15:8], gap, 1'b0);
        send_byte(c[7:0] ^ {7'd0, crc_flip}, gap, 1'b0);
`endif
    endtask

    task automatic wait_end();
        int k;
        for (k = 0; k < 300; k++) begin
            if (done === 1'b1 || error === 1'b1) break;
            tick();
        end
        if (k == 300) check("end_timeout", 32'(k), 32'(0));
        repeat (2) tick();
    endtask

    task automatic check_result(input string tag, input bit exp_ok);
        check({tag, "_done"}, 32'(done), 32'(exp_ok));
        check({tag, "_error"}, 32'(error), 32'(!exp_ok));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_shift_count"}, 32'(shift_idx - base), 32'(CHAIN_LEN));
        check({tag, "_chain"}, 32'(chain_vec()), 32'h000A_53CF);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_outputs"},
              {26'd0, cfg_if.cfg_ready, ccff_head, ccff_shift_en, busy, done, error}, 32'd0);
    endtask

    initial begin
        start            = 1'b0;
        prog_reset_n     = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = 8'h00;
        stream[0] = 8'hA5;
        stream[1] = 8'h3C;
        stream[2] = 8'hF0;
        for (int i = 0; i < CHAIN_LEN; i++) exp_bits[i] = stream[i / 8][7 - (i % 8)];
        for (int k = 0; k < CHAIN_LEN; k++) chain[k] = 1'b0;
        check("model_bit_stream", 32'(exp_vec()), 32'h000A_53CF);

        // Power-on reset
        repeat (3) tick();
        check_quiet("reset");
        prog_reset_n = 1'b1;
        tick();
        check_quiet("idle");

        // Reset mid-stream, with start asserted during reset
        pulse_start();
        send_byte(stream[0], 0, 1'b1);
        repeat (2) tick();
        prog_reset_n = 1'b0;
        start        = 1'b1;
        repeat (3) tick();
        check_quiet("midstream_reset");
        prog_reset_n = 1'b1;
        start        = 1'b0;
        tick();
        check_quiet("reset_beats_start");

        // Back-to-back bytes
        load_stream(0, 1'b0);
        wait_end();
        check_result("b2b", 1'b1);

        // Stalled bytes
        load_stream(5, 1'b0);
        wait_end();
        check_result("stall", 1'b1);

        // Overrun after done
        cfg_if.cfg_data  = 8'h00;
        cfg_if.cfg_valid = 1'b1;
        for (int k = 0; k < 10 && error !== 1'b1; k++) tick();
        cfg_if.cfg_valid = 1'b0;
        tick();
        check_result("overrun", 1'b0);
        load_stream(0, 1'b0);
        wait_end();
        check_result("after_overrun", 1'b1);

        // start during SHIFT ignored
        load_stream(0, 1'b1);
        wait_end();
        check_result("start_in_shift", 1'b1);

`ifdef CCFF_LOADER_CRC_EN
        crc_flip = 1'b1;
        load_stream(0, 1'b0);
        wait_end();
        check_result("crc_bad", 1'b0);
        crc_flip = 1'b0;
        load_stream(0, 1'b0);
        wait_end();
        check_result("crc_good", 1'b1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
